// File: rtl/test_chk_if.sv
// Receive stream into the pattern checker.
// One word is consumed on every cycle valid is high.
interface test_chk_if #(
   parameter int DW = 32
);
   logic          valid;
   logic [DW-1:0] data_in;

   modport master (output valid, data_in);
   modport slave  (input  valid, data_in);
endinterface

// File: rtl/test_chk.sv
// Incrementing test-pattern checker.
// Locks onto the first word, then counts words, errors and sync losses.
module test_chk #(
   parameter int DW       = 32,
   parameter int CW       = 32,
   parameter int EW       = 16,
   parameter int LOSS_THR = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   test_chk_if.slave     rx,
   output logic          locked,
   output logic          err_pulse,
   output logic          err_sticky,
   output logic          lost_pulse,
   output logic [CW-1:0] word_cnt,
   output logic [EW-1:0] err_cnt,
   output logic [7:0]    lost_cnt,
   output logic [DW-1:0] expected
);

   typedef enum logic {HUNT, LOCK} state_t;

   localparam logic [7:0] THR = 8'(LOSS_THR);

   state_t        state_q, state_d;
   logic [DW-1:0] exp_q, exp_d;
   logic [CW-1:0] wc_q, wc_d;
   logic [EW-1:0] ec_q, ec_d;
   logic [7:0]    lc_q, lc_d;
   logic [7:0]    consec_q, consec_d;
   logic          sticky_q, sticky_d;
   logic          errp_q, errp_d;
   logic          lostp_q, lostp_d;

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      wc_d     = wc_q;
      ec_d     = ec_q;
      lc_d     = lc_q;
      consec_d = consec_q;
      sticky_d = sticky_q;
      errp_d   = 1'b0;
      lostp_d  = 1'b0;
      if (clr) begin
         state_d  = HUNT;
         exp_d    = '0;
         wc_d     = '0;
         ec_d     = '0;
         lc_d     = '0;
         consec_d = '0;
         sticky_d = 1'b0;
      end else if (rx.valid) begin
         wc_d = wc_q + CW'(1);
         unique case (state_q)
            HUNT: begin
               exp_d    = rx.data_in + DW'(1);
               consec_d = '0;
               state_d  = LOCK;
            end
            LOCK: begin
               // expected free-runs so one bad word costs one error
               exp_d = exp_q + DW'(1);
               if (rx.data_in == exp_q) begin
                  consec_d = '0;
               end else begin
                  errp_d   = 1'b1;
                  sticky_d = 1'b1;
                  if (ec_q != '1) ec_d = ec_q + EW'(1);
                  if (consec_q + 8'd1 == THR) begin
                     state_d  = HUNT;
                     lostp_d  = 1'b1;
                     consec_d = '0;
                     if (lc_q != 8'hFF) lc_d = lc_q + 8'd1;
                  end else begin
                     consec_d = consec_q + 8'd1;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= HUNT;
         exp_q    <= '0;
         wc_q     <= '0;
         ec_q     <= '0;
         lc_q     <= '0;
         consec_q <= '0;
         sticky_q <= 1'b0;
         errp_q   <= 1'b0;
         lostp_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         wc_q     <= wc_d;
         ec_q     <= ec_d;
         lc_q     <= lc_d;
         consec_q <= consec_d;
         sticky_q <= sticky_d;
         errp_q   <= errp_d;
         lostp_q  <= lostp_d;
      end
   end

   assign locked     = (state_q == LOCK);
   assign err_pulse  = errp_q;
   assign err_sticky = sticky_q;
   assign lost_pulse = lostp_q;
   assign word_cnt   = wc_q;
   assign err_cnt    = ec_q;
   assign lost_cnt   = lc_q;
   assign expected   = exp_q;

endmodule

// File: tb/tb_test_chk.sv
// Bench for test_chk: directed table, corner sequences and
// randomized streams against a behavioural model.
module tb_test_chk;

   localparam int THR = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr;
   logic        locked, err_pulse, err_sticky, lost_pulse;
   logic [31:0] word_cnt;
   logic [15:0] err_cnt;
   logic [7:0]  lost_cnt;
   logic [31:0] expected;

   test_chk_if #(.DW(32)) rx_if ();

   test_chk #(.DW(32), .CW(32), .EW(16), .LOSS_THR(THR)) dut (
      .clk        (clk),
      .reset      (reset),
      .clr        (clr),
      .rx         (rx_if),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_sticky (err_sticky),
      .lost_pulse (lost_pulse),
      .word_cnt   (word_cnt),
      .err_cnt    (err_cnt),
      .lost_cnt   (lost_cnt),
      .expected   (expected)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   bit        m_lock, m_errp, m_lostp, m_sticky;
   bit [31:0] m_exp, m_wc;
   int        m_ec, m_lc, m_miss;

   typedef struct {
      bit        v;
      bit        c;
      bit [31:0] d;
      bit        lk;
      bit        ep;
      bit        st;
      bit        lp;
      int        wc;
      int        ec;
      int        lc;
      bit [31:0] ex;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   task automatic model_clear();
      m_lock = 0; m_errp = 0; m_lostp = 0; m_sticky = 0;
      m_exp = 0; m_wc = 0; m_ec = 0; m_lc = 0; m_miss = 0;
   endtask

   task automatic model_step(input bit r, input bit c,
                             input bit v, input bit [31:0] d);
      if (r || c) begin
         model_clear();
         return;
      end
      m_errp = 0;
      m_lostp = 0;
      if (!v) return;
      m_wc = m_wc + 1;
      if (!m_lock) begin
         m_exp = d + 1;
         m_lock = 1;
         m_miss = 0;
      end else if (d == m_exp) begin
         m_exp = m_exp + 1;
         m_miss = 0;
      end else begin
         m_exp = m_exp + 1;
         m_errp = 1;
         m_sticky = 1;
         if (m_ec < 65535) m_ec++;
         m_miss++;
         if (m_miss >= THR) begin
            m_lock = 0;
            m_lostp = 1;
            m_miss = 0;
            if (m_lc < 255) m_lc++;
         end
      end
   endtask

   task automatic check_model();
      chk("locked", locked, m_lock);
      chk("err_pulse", err_pulse, m_errp);
      chk("err_sticky", err_sticky, m_sticky);
      chk("lost_pulse", lost_pulse, m_lostp);
      chk("word_cnt", word_cnt, m_wc);
      chk("err_cnt", err_cnt, m_ec);
      chk("lost_cnt", lost_cnt, m_lc);
      chk("expected", expected, m_exp);
   endtask

   task automatic cyc(input bit r, input bit c, input bit v,
                      input bit [31:0] d);
      @(negedge clk);
      reset = r;
      clr = c;
      rx_if.valid = v;
      rx_if.data_in = d;
      @(posedge clk);
      model_step(r, c, v, d);
      #1;
      check_model();
   endtask

   task automatic add(input bit v, input bit c, input bit [31:0] d,
                      input bit lk, input bit ep, input bit st,
                      input bit lp, input int wc, input int ec,
                      input int lc, input bit [31:0] ex);
      vec_t r;
      r.v = v; r.c = c; r.d = d; r.lk = lk; r.ep = ep;
      r.st = st; r.lp = lp; r.wc = wc; r.ec = ec; r.lc = lc;
      r.ex = ex;
      tbl.push_back(r);
   endtask

   initial begin
      bit [31:0] s;
      int        sent;
      int        rate;

      reset = 1; clr = 0; rx_if.valid = 0; rx_if.data_in = 0;
      model_clear();
      cyc(1, 0, 0, 0);
      cyc(1, 0, 1, 32'h55);
      cyc(0, 0, 0, 0);
      chk("rst_locked", locked, 0);
      chk("rst_expected", expected, 0);
      chk("rst_word_cnt", word_cnt, 0);

      // 0..9 continuous
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 1, i);
         if (i == 0) chk("lock_after_w0", locked, 1);
      end
      chk("seq_wc", word_cnt, 10);
      chk("seq_ec", err_cnt, 0);
      chk("seq_sticky", err_sticky, 0);
      chk("seq_exp", expected, 10);

      // directed table from a fresh reset
      add(1,0,100,        1,0,0,0, 1,0,0, 101);
      add(1,0,101,        1,0,0,0, 2,0,0, 102);
      add(1,0,102,        1,0,0,0, 3,0,0, 103);
      add(1,0,200,        1,1,1,0, 4,1,0, 104);
      add(1,0,104,        1,0,1,0, 5,1,0, 105);
      add(1,0,105,        1,0,1,0, 6,1,0, 106);
      add(0,0,0,          1,0,1,0, 6,1,0, 106);
      add(1,0,7,          1,1,1,0, 7,2,0, 107);
      add(1,0,7,          1,1,1,0, 8,3,0, 108);
      add(1,0,7,          1,1,1,0, 9,4,0, 109);
      add(1,0,7,          0,1,1,1, 10,5,1, 110);
      add(1,0,500,        1,0,1,0, 11,5,1, 501);
      add(1,0,501,        1,0,1,0, 12,5,1, 502);
      add(1,1,77,         0,0,0,0, 0,0,0, 0);
      add(1,0,42,         1,0,0,0, 1,0,0, 43);
      add(0,1,0,          0,0,0,0, 0,0,0, 0);
      add(1,0,32'hFFFFFFFE,1,0,0,0, 1,0,0, 32'hFFFFFFFF);
      add(1,0,32'hFFFFFFFF,1,0,0,0, 2,0,0, 0);
      add(1,0,0,          1,0,0,0, 3,0,0, 1);
      add(1,0,1,          1,0,0,0, 4,0,0, 2);

      cyc(1, 0, 0, 0);
      foreach (tbl[i]) begin
         cyc(0, tbl[i].c, tbl[i].v, tbl[i].d);
         chk($sformatf("t%0d_locked", i), locked, tbl[i].lk);
         chk($sformatf("t%0d_errp", i), err_pulse, tbl[i].ep);
         chk($sformatf("t%0d_sticky", i), err_sticky, tbl[i].st);
         chk($sformatf("t%0d_lostp", i), lost_pulse, tbl[i].lp);
         chk($sformatf("t%0d_wc", i), word_cnt, tbl[i].wc);
         chk($sformatf("t%0d_ec", i), err_cnt, tbl[i].ec);
         chk($sformatf("t%0d_lc", i), lost_cnt, tbl[i].lc);
         chk($sformatf("t%0d_exp", i), expected, tbl[i].ex);
      end

      // 1000 clean words with gaps in valid
      cyc(0, 1, 0, 0);
      s = $urandom;
      sent = 0;
      while (sent < 1000) begin
         if ($urandom_range(0, 2) == 0) begin
            cyc(0, 0, 0, $urandom);
         end else begin
            cyc(0, 0, 1, s);
            s = s + 1;
            sent++;
         end
      end
      chk("gap_wc", word_cnt, 1000);
      chk("gap_ec", err_cnt, 0);
      chk("gap_locked", locked, 1);

      // lost_cnt saturation: seed then THR bad words, repeated
      cyc(0, 1, 0, 0);
      for (int k = 0; k < 260; k++) begin
         cyc(0, 0, 1, 32'h1000);
         for (int j = 0; j < THR; j++)
            cyc(0, 0, 1, 32'h0);
      end
      chk("lc_sat", lost_cnt, 255);
      chk("lc_ec", err_cnt, 260 * THR);

      // randomized mixed stream
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         bit        v, c;
         bit [31:0] d;
         rate = ((i / 400) % 2 == 0) ? 12 : 2;
         c = ($urandom_range(0, 199) == 0);
         v = ($urandom_range(0, 2) != 0);
         if (m_lock && $urandom_range(0, rate - 1) != 0)
            d = m_exp;
         else
            d = $urandom;
         cyc(0, c, v, d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
